// File: rtl/ln_pkg.sv
// ln_pkg: shared constants, coefficient table and FSM state type for ln_horner_seq.
// Coefficients are Q16 values of the 5th-order ln(1+x) polynomial, index 0 = constant term.
package ln_pkg;

    localparam int LN_N    = 5;
    localparam int LN_FRAC = 16;
    localparam int LN_W    = 17;

    localparam logic signed [LN_W:0] LN_COEF [LN_N+1] = '{
        18'sd1,
        18'sd65481,
        -18'sd32093,
        18'sd18601,
        -18'sd8517,
        18'sd1954
    };

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } ln_state_e;

    // Table lookup with constant indices only; out-of-range k reads as 0.
    function automatic logic signed [LN_W:0] ln_coef(input int k);
        logic signed [LN_W:0] r;
        r = '0;
        for (int i = 0; i <= LN_N; i++) begin
            if (i == k) r = LN_COEF[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ln_horner_seq_if.sv
// ln_horner_seq_if: valid/ready bundle for argument in and result out.
// master = sample source/sink side, slave = evaluator side; sat_flag exists only with LN_SAT_EN.
interface ln_horner_seq_if #(
    parameter int W = ln_pkg::LN_W
);

    logic signed [W:0] x_in;
    logic              in_valid;
    logic              in_ready;
    logic signed [W:0] f_out;
    logic              out_valid;
    logic              out_ready;
`ifdef LN_SAT_EN
    logic              sat_flag;
`endif

    modport master (
        output x_in,
        output in_valid,
        input  in_ready,
        input  f_out,
        input  out_valid,
        output out_ready
`ifdef LN_SAT_EN
        ,
        input  sat_flag
`endif
    );

    modport slave (
        input  x_in,
        input  in_valid,
        output in_ready,
        output f_out,
        output out_valid,
        input  out_ready
`ifdef LN_SAT_EN
        ,
        output sat_flag
`endif
    );

endinterface

// File: rtl/ln_horner_step.sv
// ln_horner_step: one Horner step, nxt = ((x*acc) >>> 16) + coef, combinational.
// Ports: x, acc, coef in; nxt out; sat out only when LN_SAT_EN is defined (saturating sum).
module ln_horner_step
    import ln_pkg::*;
#(
    parameter int W = LN_W
) (
    input  logic signed [W:0] x,
    input  logic signed [W:0] acc,
    input  logic signed [W:0] coef,
    output logic signed [W:0] nxt
`ifdef LN_SAT_EN
    ,
    output logic              sat
`endif
);

    localparam int PW = 2 * (W + 1);

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shf;
    logic signed [PW-1:0] cext;
    logic signed [PW-1:0] sum;

    // Full-width product, so the shifted value and sum cannot overflow here.
    assign prod = x * acc;
    assign shf  = prod >>> LN_FRAC;
    assign cext = {{(PW-W-1){coef[W]}}, coef};
    assign sum  = shf + cext;

`ifdef LN_SAT_EN
    logic hi_ones;
    logic hi_zeros;

    // Fits in W+1 bits only if bits PW-1..W are all equal.
    assign hi_ones  = &sum[PW-1:W];
    assign hi_zeros = ~|sum[PW-1:W];
    assign sat      = !(hi_ones || hi_zeros);

    always_comb begin
        nxt = sum[W:0];
        if (sat) begin
            nxt = sum[PW-1] ? {1'b1, {W{1'b0}}} : {1'b0, {W{1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^sum[PW-1:W+1];
    assign nxt       = sum[W:0];
`endif

endmodule

// File: rtl/ln_horner_seq.sv
// ln_horner_seq: multi-cycle ln(1+x) evaluator, one Horner step per clock on a shared step unit.
// Ports: clk, reset (async, active-high), bus (slave: x_in/in_valid/in_ready, f_out/out_valid/out_ready, sat_flag with LN_SAT_EN).
module ln_horner_seq
    import ln_pkg::*;
#(
    parameter int N = LN_N,
    parameter int W = LN_W
) (
    input  logic           clk,
    input  logic           reset,
    ln_horner_seq_if.slave bus
);

    localparam int KW = $clog2(N + 1);

    ln_state_e         state_q;
    ln_state_e         state_d;
    logic signed [W:0] x_q;
    logic signed [W:0] acc_q;
    logic [KW-1:0]     k_q;
    logic signed [W:0] f_q;
    logic signed [W:0] cf;
    logic signed [W:0] nxt;
    logic              load;
    logic              step;
    logic              last;
`ifdef LN_SAT_EN
    logic              step_sat;
    logic              sat_q;
`endif

    assign cf = (W+1)'(ln_coef(int'(k_q)));

    ln_horner_step #(
        .W (W)
    ) u_step (
        .x    (x_q),
        .acc  (acc_q),
        .coef (cf),
        .nxt  (nxt)
`ifdef LN_SAT_EN
        ,
        .sat  (step_sat)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        step          = 1'b0;
        last          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = ITER;
                end
            end
            ITER: begin
                step = 1'b1;
                if (k_q == '0) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            acc_q <= '0;
            k_q   <= '0;
            f_q   <= '0;
`ifdef LN_SAT_EN
            sat_q <= 1'b0;
`endif
        end else if (load) begin
            x_q   <= bus.x_in;
            acc_q <= (W+1)'(ln_coef(N));
            k_q   <= KW'(N - 1);
`ifdef LN_SAT_EN
            sat_q <= 1'b0;
`endif
        end else if (step) begin
            acc_q <= nxt;
            if (last) f_q <= nxt;
            else      k_q <= k_q - 1'b1;
`ifdef LN_SAT_EN
            sat_q <= sat_q | step_sat;
`endif
        end
    end

    assign bus.f_out = f_q;
`ifdef LN_SAT_EN
    assign bus.sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_ln_horner_seq.sv
// tb_ln_horner_seq: randomized and directed checks of ln_horner_seq against an arithmetic model.
// Covers latency, back-pressure, async reset mid-evaluation and overflow vectors (LN_SAT_EN aware).
module tb_ln_horner_seq;

    localparam longint COEF [6] = '{1, 65481, -32093, 18601, -8517, 1954};
    localparam longint MAXV = 131071;
    localparam longint MINV = -131072;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ln_horner_seq_if bus ();

    ln_horner_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ln(1+x) polynomial evaluated step by step with exact floor division.
    function automatic longint model(input longint x, output bit sat, output bit ovf_last);
        longint acc;
        longint p;
        longint q;
        longint s;
        bit     ovf;
        sat      = 1'b0;
        ovf_last = 1'b0;
        acc      = COEF[5];
        for (int k = 4; k >= 0; k--) begin
            p = x * acc;
            q = p / 65536;
            if (p < 0 && (p % 65536) != 0) q = q - 1;
            s   = q + COEF[k];
            ovf = (s > MAXV) || (s < MINV);
            if (ovf) sat = 1'b1;
            if (k == 0) ovf_last = ovf;
`ifdef LN_SAT_EN
            if (s > MAXV) s = MAXV;
            else if (s < MINV) s = MINV;
`else
            s = s & 262143;
            if (s >= 131072) s = s - 262144;
`endif
            acc = s;
        end
        return acc;
    endfunction

    // Starts at posedge+1 in IDLE; ends at posedge+1 back in IDLE.
    task automatic send(input int x, input int hold);
        longint            exp;
        bit                esat;
        bit                eovf;
        int                cnt;
        logic signed [17:0] xr;
        xr  = 18'(x);
        exp = model(longint'(xr), esat, eovf);
        bus.x_in      = xr;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x_in     = 18'($urandom);
        check("busy_ready", longint'(bus.in_ready), 0);
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency", cnt, 5);
        check("f_out", longint'(bus.f_out), exp);
`ifdef LN_SAT_EN
        check("sat_flag", longint'(bus.sat_flag), longint'(esat));
`endif
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom);
            bus.x_in     = 18'($urandom);
            @(posedge clk);
            #1;
            check("stall_valid", longint'(bus.out_valid), 1);
            check("stall_f", longint'(bus.f_out), exp);
            check("stall_ready", longint'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready", longint'(bus.in_ready), 1);
        check("idle_valid", longint'(bus.out_valid), 0);
    endtask

    initial begin
        bit               s;
        bit               o;
        bit               found;
        int               ovf_x;
        logic signed [17:0] r;

        reset         = 1'b1;
        bus.x_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_ready", longint'(bus.in_ready), 1);
        check("rst_valid", longint'(bus.out_valid), 0);
        check("rst_f", longint'(bus.f_out), 0);
`ifdef LN_SAT_EN
        check("rst_sat", longint'(bus.sat_flag), 0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        send(0, 0);
        send(65536, 0);
        send(32768, 0);
        send(-131072, 0);
        send(131071, 0);
        send(-65536, 0);

        // Find an argument whose last step overflows the result range.
        found = 1'b0;
        ovf_x = 0;
        for (int x = -131072; x <= 131071; x++) begin
            void'(model(longint'(x), s, o));
            if (o && !found) begin
                found = 1'b1;
                ovf_x = x;
            end
        end
        if (found) send(ovf_x, 0);
        else $display("note: no last-step overflow argument exists");

        // Back-pressure with input chatter while the result is held.
        send(65536, 10);

        // Reset during the second Horner step.
        bus.x_in     = 18'sd65536;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", longint'(bus.in_ready), 1);
        check("mid_rst_valid", longint'(bus.out_valid), 0);
        check("mid_rst_f", longint'(bus.f_out), 0);
`ifdef LN_SAT_EN
        check("mid_rst_sat", longint'(bus.sat_flag), 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_rst_ready", longint'(bus.in_ready), 1);
        send(65536, 0);

        for (int i = 0; i < 40; i++) begin
            r = 18'($urandom);
            send(int'(r), (i % 8 == 3) ? 3 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
